// File: rtl/rbus_pkg.sv
// Shared rbus definitions: bus geometry, beat record, demux FSM states and
// the round-robin pointer increment used by the demultiplexer.
package rbus_pkg;

  localparam int unsigned RBUS_DW      = 72;
  localparam int unsigned RBUS_LEN_BIT = 39;

  typedef struct packed {
    logic               sof;
    logic [RBUS_DW-1:0] data;
  } rbus_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } demux_st_e;

  // Next channel after p, wrapping from n-1 back to 0.
  function automatic logic [2:0] ptr_inc(input logic [2:0] p, input int unsigned n);
    if (32'(p) == n - 1) begin
      return 3'd0;
    end
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/rbus_rr_sel.sv
// Round-robin channel selector for one packet class. In strict mode the
// pointer is the selection; with skip_en the first credited channel at or
// above the pointer (wrapping) is chosen, falling back to the pointer when
// no channel has credit.
module rbus_rr_sel #(
  parameter int unsigned CHANNELS = 4
) (
  input  logic [2:0]          ptr_i,
  input  logic [CHANNELS-1:0] credit_i,
  input  logic                skip_en_i,
  output logic [2:0]          sel_o,
  output logic                any_rdy_o
);

  logic found;

  // Two-pass upward search: channels at/above ptr first, then the wrapped part.
  always_comb begin
    sel_o     = ptr_i;
    found     = 1'b0;
    any_rdy_o = |credit_i;
    if (skip_en_i) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (!found && (c >= 32'(ptr_i)) && credit_i[c]) begin
          sel_o = 3'(c);
          found = 1'b1;
        end
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (!found && (c < 32'(ptr_i)) && credit_i[c]) begin
          sel_o = 3'(c);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rbus_demux1ton.sv
// Packet-level 1-to-N rbus demultiplexer. Headers pick a channel from the
// per-class round-robin pointer; payload beats follow the latched target
// until the next header. Credits gate only the ready indication, there is
// no internal buffering. Optional feature macro: RBUS_DEMUX_SKIP_BUSY_EN
// (skip channels without credit during selection).
module rbus_demux1ton
  import rbus_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DEMUX_RATIO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stb,
  input  logic                  i_sof,
  input  logic [RBUS_DW-1:0]    i_data,
  output logic [1:0]            i_rdy,
  output logic [CHANNELS-1:0]   o_stb,
  output logic                  o_sof,
  output logic [RBUS_DW-1:0]    o_data,
  input  logic [2*CHANNELS-1:0] o_rdy,
  output logic                  err
);

`ifdef RBUS_DEMUX_SKIP_BUSY_EN
  localparam logic SKIP_BUSY = 1'b1;
`else
  localparam logic SKIP_BUSY = 1'b0;
`endif

  demux_st_e state_q, state_d;

  logic [1:0][2:0] ptr_q, ptr_d;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic [2:0]      tgt_q, tgt_d;
  logic            err_q, err_d;
  logic [CHANNELS-1:0] stb_q, stb_d;
  rbus_beat_t      beat_q, beat_d;

  logic [CHANNELS-1:0] cred_s, cred_l;
  logic [1:0][2:0]     sel;
  logic [1:0]          any_rdy;
  logic [1:0]          rdy;

  logic       hdr, pay, cls;
  logic       fwd, orphan;
  logic [2:0] route;
  logic [1:0] hdr_cls;

  assign hdr        = i_stb & i_sof;
  assign pay        = i_stb & ~i_sof;
  assign cls        = i_data[RBUS_LEN_BIT];
  assign hdr_cls[0] = hdr & ~cls;
  assign hdr_cls[1] = hdr & cls;

  // Split the interleaved credit vector into per-class channel vectors.
  always_comb begin
    cred_s = '0;
    cred_l = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      cred_s[c] = o_rdy[2*c];
      cred_l[c] = o_rdy[2*c+1];
    end
  end

  rbus_rr_sel #(.CHANNELS(CHANNELS)) u_sel_s (
    .ptr_i     (ptr_q[0]),
    .credit_i  (cred_s),
    .skip_en_i (SKIP_BUSY),
    .sel_o     (sel[0]),
    .any_rdy_o (any_rdy[0])
  );

  rbus_rr_sel #(.CHANNELS(CHANNELS)) u_sel_l (
    .ptr_i     (ptr_q[1]),
    .credit_i  (cred_l),
    .skip_en_i (SKIP_BUSY),
    .sel_o     (sel[1]),
    .any_rdy_o (any_rdy[1])
  );

  // Ready per class: credit of the selected channel, or any credit when skipping.
  always_comb begin
    rdy = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (sel[0] == 3'(c)) rdy[0] = cred_s[c];
      if (sel[1] == 3'(c)) rdy[1] = cred_l[c];
    end
    if (SKIP_BUSY) begin
      rdy = any_rdy;
    end
  end

  assign i_rdy = rdy;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: any header opens (or restarts) a packet.
  always_comb begin
    state_d = state_q;
    if (hdr) state_d = PKT;
  end

  // FSM outputs: forward decision, orphan detection and routing target.
  always_comb begin
    fwd    = hdr | (pay & (state_q == PKT));
    orphan = pay & (state_q == IDLE);
    route  = hdr ? sel[cls] : tgt_q;
    tgt_d  = route;
  end

  // Per-class pointer/counter advance on that class's headers. A skip to a
  // different channel restarts the burst just past the chosen channel.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (hdr_cls[k]) begin
        if (SKIP_BUSY && (sel[k] != ptr_q[k])) begin
          ptr_d[k] = ptr_inc(sel[k], CHANNELS);
          cnt_d[k] = '0;
        end else if (cnt_q[k] == 4'(DEMUX_RATIO - 1)) begin
          ptr_d[k] = ptr_inc(ptr_q[k], CHANNELS);
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 4'd1;
        end
      end
    end
  end

  // Output beat, one-hot strobe and sticky error next-state.
  always_comb begin
    stb_d  = '0;
    beat_d = beat_q;
    err_d  = err_q | orphan | (hdr & ~rdy[cls]);
    if (fwd) begin
      beat_d.sof  = i_sof;
      beat_d.data = i_data;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        stb_d[c] = (route == 3'(c));
      end
    end
  end

  // Datapath and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      tgt_q  <= '0;
      err_q  <= 1'b0;
      stb_q  <= '0;
      beat_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      tgt_q  <= fwd ? tgt_d : tgt_q;
      err_q  <= err_d;
      stb_q  <= stb_d;
      beat_q <= beat_d;
    end
  end

  assign o_stb  = stb_q;
  assign o_sof  = beat_q.sof;
  assign o_data = beat_q.data;
  assign err    = err_q;

endmodule

// File: tb/tb_rbus_demux1ton.sv
// Directed bench for rbus_demux1ton: three instances (4ch ratio 1, 4ch
// ratio 2, 3ch ratio 1) share one stimulus stream; each scenario checks
// the instance it targets.
module tb_rbus_demux1ton;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_stb = 1'b0;
  logic        i_sof = 1'b0;
  logic [71:0] i_data = '0;
  logic [7:0]  o_rdy = '1;

  logic [1:0]  i_rdy, i_rdy_r2, i_rdy_c3;
  logic [3:0]  o_stb, o_stb_r2;
  logic [2:0]  o_stb_c3;
  logic        o_sof, o_sof_r2, o_sof_c3;
  logic [71:0] o_data, o_data_r2, o_data_c3;
  logic        err, err_r2, err_c3;
  logic [5:0]  o_rdy_c3;

  int passed = 0;
  int total  = 0;

  assign o_rdy_c3 = o_rdy[5:0];

  always #5 clk = ~clk;

  rbus_demux1ton #(.CHANNELS(4), .DEMUX_RATIO(1)) dut (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
    .i_rdy(i_rdy), .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data),
    .o_rdy(o_rdy), .err(err)
  );

  rbus_demux1ton #(.CHANNELS(4), .DEMUX_RATIO(2)) dut_r2 (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
    .i_rdy(i_rdy_r2), .o_stb(o_stb_r2), .o_sof(o_sof_r2), .o_data(o_data_r2),
    .o_rdy(o_rdy), .err(err_r2)
  );

  rbus_demux1ton #(.CHANNELS(3), .DEMUX_RATIO(1)) dut_c3 (
    .clk(clk), .rst(rst), .i_stb(i_stb), .i_sof(i_sof), .i_data(i_data),
    .i_rdy(i_rdy_c3), .o_stb(o_stb_c3), .o_sof(o_sof_c3), .o_data(o_data_c3),
    .o_rdy(o_rdy_c3), .err(err_c3)
  );

  function automatic logic [71:0] mk(input int unsigned tag, input logic lng);
    logic [71:0] d;
    d     = 72'(tag & 32'hFF) | (72'hC3 << 56);
    d[39] = lng;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_stb = 1'b0; i_sof = 1'b0; i_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    o_rdy = '1;
    @(negedge clk);
    i_stb = 1'b1; i_sof = 1'b1; i_data = mk(7, 1'b0);
    do_reset();
    total++; if (o_stb !== 4'b0000) $display("FAIL reset_stb got %b expected 0000", o_stb); else passed++;
    total++; if (o_sof !== 1'b0) $display("FAIL reset_sof got %b expected 0", o_sof); else passed++;
    total++; if (o_data !== 72'h0) $display("FAIL reset_data got %h expected 0", o_data); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b expected 0", err); else passed++;
    total++; if (o_stb_c3 !== 3'b000) $display("FAIL reset_stb_c3 got %b expected 000", o_stb_c3); else passed++;
    o_rdy = 8'b0000_0011;
    #1;
    total++; if (i_rdy !== 2'b11) $display("FAIL reset_rdy_ch0 got %b expected 11", i_rdy); else passed++;
    o_rdy = 8'b1111_1110;
    #1;
`ifdef RBUS_DEMUX_SKIP_BUSY_EN
    total++; if (i_rdy !== 2'b11) $display("FAIL reset_rdy_noch0s got %b expected 11", i_rdy); else passed++;
`else
    total++; if (i_rdy !== 2'b10) $display("FAIL reset_rdy_noch0s got %b expected 10", i_rdy); else passed++;
`endif
    o_rdy = '1;
  endtask

  task automatic test_rr_short();
    logic [71:0] prev_d;
    logic        prev_sof;
    logic [3:0]  prev_exp;
    prev_d = '0; prev_sof = 1'b0; prev_exp = '0;
    do_reset();
    o_rdy = '1;
    for (int j = 0; j <= 24; j++) begin
      @(negedge clk);
      if (j > 0) begin
        total++; if (o_stb !== prev_exp) $display("FAIL rr_stb beat %0d got %b expected %b", j-1, o_stb, prev_exp); else passed++;
        total++; if (o_data !== prev_d) $display("FAIL rr_data beat %0d got %h expected %h", j-1, o_data, prev_d); else passed++;
        total++; if (o_sof !== prev_sof) $display("FAIL rr_sof beat %0d got %b expected %b", j-1, o_sof, prev_sof); else passed++;
      end
      if (j < 24) begin
        i_stb = 1'b1; i_sof = ((j % 3) == 0); i_data = mk(j, 1'b0);
        prev_d = i_data; prev_sof = i_sof; prev_exp = 4'(1 << ((j / 3) % 4));
      end else begin
        i_stb = 1'b0; i_sof = 1'b0; i_data = '0;
      end
    end
    @(negedge clk);
    total++; if (o_stb !== 4'b0000) $display("FAIL rr_idle_stb got %b expected 0000", o_stb); else passed++;
    total++; if (o_data !== prev_d) $display("FAIL rr_hold_data got %h expected %h", o_data, prev_d); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rr_err got %b expected 0", err); else passed++;
  endtask

  task automatic test_ratio2();
    logic [3:0] prev_exp;
    prev_exp = '0;
    do_reset();
    o_rdy = '1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (o_stb_r2 !== prev_exp) $display("FAIL ratio2_stb hdr %0d got %b expected %b", i-1, o_stb_r2, prev_exp); else passed++;
      end
      if (i < 12) begin
        i_stb = 1'b1; i_sof = 1'b1; i_data = mk(i, ((i % 2) == 0));
        prev_exp = 4'(1 << (((i / 2) / 2) % 4));
      end else begin
        i_stb = 1'b0; i_sof = 1'b0;
      end
    end
    total++; if (err_r2 !== 1'b0) $display("FAIL ratio2_err got %b expected 0", err_r2); else passed++;
  endtask

  task automatic test_credit();
    do_reset();
    o_rdy = '1;
    @(negedge clk);
    i_stb = 1'b1; i_sof = 1'b1; i_data = mk(1, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0001) $display("FAIL credit_first got %b expected 0001", o_stb); else passed++;
    i_stb = 1'b0; i_sof = 1'b0;
`ifdef RBUS_DEMUX_SKIP_BUSY_EN
    o_rdy = 8'hFF & ~8'h14;
    #1;
    total++; if (i_rdy[0] !== 1'b1) $display("FAIL skip_rdy got %b expected 1", i_rdy[0]); else passed++;
    @(negedge clk);
    i_stb = 1'b1; i_sof = 1'b1; i_data = mk(2, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b1000) $display("FAIL skip_stb got %b expected 1000", o_stb); else passed++;
    total++; if (err !== 1'b0) $display("FAIL skip_err got %b expected 0", err); else passed++;
    o_rdy = '1;
    i_data = mk(3, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0001) $display("FAIL skip_ptr_wrap got %b expected 0001", o_stb); else passed++;
`else
    o_rdy = 8'hFF & ~8'h04;
    #1;
    total++; if (i_rdy !== 2'b10) $display("FAIL strict_rdy got %b expected 10", i_rdy); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL strict_err_pre got %b expected 0", err); else passed++;
    i_stb = 1'b1; i_sof = 1'b1; i_data = mk(2, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0010) $display("FAIL strict_stb got %b expected 0010", o_stb); else passed++;
    total++; if (err !== 1'b1) $display("FAIL strict_err got %b expected 1", err); else passed++;
    o_rdy = '1;
    i_data = mk(3, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0100) $display("FAIL strict_ptr_adv got %b expected 0100", o_stb); else passed++;
    total++; if (err !== 1'b1) $display("FAIL strict_err_sticky got %b expected 1", err); else passed++;
`endif
    i_stb = 1'b0; i_sof = 1'b0;
  endtask

  task automatic test_orphan_reset();
    do_reset();
    o_rdy = '1;
    @(negedge clk);
    i_stb = 1'b1; i_sof = 1'b0; i_data = mk(9, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0000) $display("FAIL orphan_stb got %b expected 0000", o_stb); else passed++;
    total++; if (err !== 1'b1) $display("FAIL orphan_err got %b expected 1", err); else passed++;
    do_reset();
    @(negedge clk);
    i_stb = 1'b1; i_sof = 1'b1; i_data = mk(10, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0001) $display("FAIL midrst_hdr got %b expected 0001", o_stb); else passed++;
    i_sof = 1'b0; i_data = mk(11, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0001) $display("FAIL midrst_pay got %b expected 0001", o_stb); else passed++;
    rst = 1'b1; i_data = mk(12, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0000) $display("FAIL midrst_stb got %b expected 0000", o_stb); else passed++;
    total++; if (o_data !== 72'h0) $display("FAIL midrst_data got %h expected 0", o_data); else passed++;
    rst = 1'b0; i_data = mk(13, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0000) $display("FAIL midrst_drop got %b expected 0000", o_stb); else passed++;
    total++; if (err !== 1'b1) $display("FAIL midrst_err got %b expected 1", err); else passed++;
    i_sof = 1'b1; i_data = mk(14, 1'b0);
    @(negedge clk);
    total++; if (o_stb !== 4'b0001) $display("FAIL midrst_ptr got %b expected 0001", o_stb); else passed++;
    i_stb = 1'b0; i_sof = 1'b0;
  endtask

  task automatic test_wrap_c3();
    logic [2:0] prev_exp;
    prev_exp = '0;
    do_reset();
    o_rdy = '1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (o_stb_c3 !== prev_exp) $display("FAIL c3_wrap hdr %0d got %b expected %b", i-1, o_stb_c3, prev_exp); else passed++;
      end
      if (i < 7) begin
        i_stb = 1'b1; i_sof = 1'b1; i_data = mk(20 + i, 1'b1);
        prev_exp = 3'(1 << (i % 3));
      end else begin
        i_stb = 1'b0; i_sof = 1'b0;
      end
    end
    total++; if (err_c3 !== 1'b0) $display("FAIL c3_err got %b expected 0", err_c3); else passed++;
  endtask

  initial begin
    test_reset();
    test_rr_short();
    test_ratio2();
    test_credit();
    test_orphan_reset();
    test_wrap_c3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
